// File: rtl/eio_ctrl.sv
// External I/O window controller: decodes CPU requests into a 4-slot peripheral
// window, waits for the selected slot's acknowledge with a timeout, then reports completion or fault.
module eio_ctrl #(
    parameter logic [31:0] EIO_BASE = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          req_in,
    input  logic          wr_in,
    input  logic [31:0]   addr_in,
    input  logic [31:0]   wdata_in,
    output logic          ack_out,
    output logic          ack_fault_out,
    output logic [31:0]   ack_data_out,
    output logic [3:0]    p_req_out,
    output logic          p_wr_out,
    output logic [11:0]   p_addr_out,
    output logic [31:0]   p_wdata_out,
    input  logic [3:0]    p_ack_in,
    input  logic [127:0]  p_rdata_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last WAIT count at which a missing acknowledge becomes a fault.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  slot_q;
    logic [7:0]  wait_cnt;
    logic        fault_q;
    logic        hit;
    logic        slot_ack;
    logic        timed_out;

    always_comb begin
        hit       = (addr_in[31:16] == EIO_BASE[31:16]) &&
                    (addr_in[15:14] == 2'b00) &&
                    (addr_in[1:0] == 2'b00);
        slot_ack  = p_ack_in[slot_q];
        timed_out = (wait_cnt == TO_LAST);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_in) begin
                    state_nxt = hit ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (slot_ack || timed_out) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Acknowledge from the selected slot takes precedence over the timeout.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            slot_q        <= 2'd0;
            wait_cnt      <= 8'd0;
            fault_q       <= 1'b0;
            ack_out       <= 1'b0;
            ack_fault_out <= 1'b0;
            ack_data_out  <= 32'd0;
            p_req_out     <= 4'b0000;
            p_wr_out      <= 1'b0;
            p_addr_out    <= 12'd0;
            p_wdata_out   <= 32'd0;
        end else begin
            ack_out       <= (state == RESP) && !fault_q;
            ack_fault_out <= (state == RESP) && fault_q;
            case (state)
                IDLE: begin
                    if (req_in) begin
                        if (hit) begin
                            slot_q      <= addr_in[13:12];
                            wait_cnt    <= 8'd0;
                            fault_q     <= 1'b0;
                            p_req_out   <= 4'b0001 << addr_in[13:12];
                            p_wr_out    <= wr_in;
                            p_addr_out  <= addr_in[11:0];
                            p_wdata_out <= wdata_in;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (slot_ack) begin
                        fault_q   <= 1'b0;
                        p_req_out <= 4'b0000;
                        if (!p_wr_out) begin
                            ack_data_out <= p_rdata_in[{slot_q, 5'd0} +: 32];
                        end
                    end else if (timed_out) begin
                        fault_q   <= 1'b1;
                        p_req_out <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/eio_ctrl.md
EIO_CTRL -- requirements
Module: eio_ctrl

Interface
REQ-001 Parameters SHALL be: EIO_BASE, default 32'hFFFF_0000, window base (bits 31:16 compared); TIMEOUT, default 16, max WAIT cycles before fault (range 2..255).
REQ-002 Ports SHALL be, in this order:
- clk_in  input  1  clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- req_in  input  1  CPU EIO request, held until ack_out or ack_fault_out.
- wr_in  input  1  1 = write, 0 = read.
- addr_in  input  32  byte address.
- wdata_in  input  32  write data.
- ack_out  output  1  one-cycle completion pulse.
- ack_fault_out  output  1  one-cycle fault pulse.
- ack_data_out  output  32  read data, valid with ack_out.
- p_req_out  output  4  one-hot request to peripheral slot 0..3.
- p_wr_out  output  1  latched wr_in.
- p_addr_out  output  12  latched addr_in[11:0].
- p_wdata_out  output  32  latched wdata_in.
- p_ack_in  input  4  per-slot acknowledge.
- p_rdata_in  input  128  slot n read data in bits [32n+31:32n].

Function
REQ-003 FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-004 Hit SHALL be addr_in[31:16]==EIO_BASE[31:16], addr_in[15:14]==0 and addr_in[1:0]==0; slot = addr_in[13:12].
REQ-005 IDLE with req_in=1 and hit: latch wr/addr[11:0]/wdata/slot, go WAIT; p_req_out[slot]=1 from the next cycle.
REQ-006 IDLE with req_in=1 and miss (window, bits 15:14 or misalignment): go RESP with fault flag set; no p_req_out asserted.
REQ-007 WAIT: p_req_out SHALL stay one-hot on the latched slot with p_wr/p_addr/p_wdata stable until exit.
REQ-008 WAIT with p_ack_in[slot]=1: capture p_rdata_in[slot] (reads only, else keep previous value), clear fault flag, go RESP; p_req_out=0 from the next cycle.
REQ-009 p_ack_in bits of non-selected slots, and any p_ack_in outside WAIT, SHALL be ignored.
REQ-010 8-bit wait counter SHALL clear on IDLE->WAIT and increment each WAIT cycle without an ack; when it equals TIMEOUT-1 with no ack, go RESP with fault flag set.
REQ-011 Ack on the timeout cycle SHALL win: normal completion, no fault.
REQ-012 RESP lasts exactly one cycle: ack_out=!fault, ack_fault_out=fault, never both; then IDLE.
REQ-013 req_in in WAIT or RESP SHALL be ignored; a still-high req_in in the first IDLE cycle after RESP starts a new transaction.
REQ-014 ack_data_out SHALL hold its last captured value between transactions; on writes and faults it is don't-care but unchanged.
REQ-015 Latency: hit with p_ack in first WAIT cycle -> ack_out 2 cycles after req_in sampled; miss -> ack_fault_out 1 cycle after; timeout -> ack_fault_out TIMEOUT+1 cycles after.
REQ-016 All outputs SHALL be registered; no combinational path from p_ack_in or req_in to any output.

Reset
REQ-017 reset_in=1 at a clock edge SHALL force IDLE, counter 0, fault flag 0, and at that edge ack_out=0, ack_fault_out=0, p_req_out=4'b0, p_wr_out=0, p_addr_out=0, p_wdata_out=0, ack_data_out=0.
REQ-018 Reset during WAIT or RESP SHALL abort the transaction with no ack or fault pulse; reset has priority over every transition.

Verification
REQ-019 Read hit: addr 32'hFFFF_1004, wr=0, slot1 acks in first WAIT cycle with 32'h1234_5678 -> p_req_out=4'b0010 one cycle, p_addr_out=12'h004, ack_out 2 cycles after request, ack_data_out=32'h1234_5678.
REQ-020 Write hit, slot3 acks after 5 WAIT cycles: addr 32'hFFFF_3010, wdata 32'hDEADBEEF -> p_wr_out=1, p_wdata_out=32'hDEADBEEF for 6 cycles, then single ack_out.
REQ-021 Misses: addr 32'h8000_0000, then 32'hFFFF_4000, then 32'hFFFF_0002 -> ack_fault_out 1 cycle after each request, p_req_out stays 0.
REQ-022 Timeout: slot 2 never acks, TIMEOUT=16 -> p_req_out=4'b0100 for 16 cycles, ack_fault_out at cycle 17, ack_out stays 0.
REQ-023 Corner cases: slot 0 acks exactly on cycle 16 -> ack_out, no fault; ack from wrong slot 1 while slot 0 selected -> ignored, timeout fault.
REQ-024 Reset mid-WAIT, slot 0 selected -> p_req_out=0 and no ack pulse after the reset edge; the next request completes normally.
